// File: rtl/led_scan_scheduler_pkg.sv
// led_scan_pkg: scan FSM states, lane indices and default slot timing shared by the LED scan scheduler
package led_scan_pkg;
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, SHIFT = 3'd2, LATCH = 3'd3, BLANK = 3'd4;
  typedef enum logic [2:0] {
    ST_IDLE = IDLE, ST_LOAD = LOAD, ST_SHIFT = SHIFT, ST_LATCH = LATCH, ST_BLANK = BLANK
  } state_e;
  localparam int LANES = 4;
  localparam logic [1:0] LANE_A = 2'd0, LANE_B = 2'd1, LANE_C = 2'd2, LANE_D = 2'd3;
  localparam int SLOT_LEN_DEF = 1 + 32 + 1 + 3;
endpackage

// File: rtl/led_scan_scheduler_if.sv
// led_scan_if: host write port plus panel-side scan outputs of the LED scan scheduler
interface led_scan_if
  import led_scan_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int WORD_W = 32
);
  localparam int DW = $clog2(NUM_DEV);
  logic enable;
  logic wr_en;
  logic [DW-1:0] wr_dev;
  logic [1:0] wr_lane;
  logic [WORD_W-1:0] wr_data;
  logic [LANES-1:0] sdo;
  logic shift_en;
  logic [NUM_DEV-1:0] latch;
  logic blank;
  logic busy;
  logic [DW-1:0] cur_dev;
  logic dev_done;
  modport master (
    output enable, wr_en, wr_dev, wr_lane, wr_data,
    input sdo, shift_en, latch, blank, busy, cur_dev, dev_done
  );
  modport slave (
    input enable, wr_en, wr_dev, wr_lane, wr_data,
    output sdo, shift_en, latch, blank, busy, cur_dev, dev_done
  );
endinterface

// File: rtl/led_scan_scheduler_lane_shifter.sv
// led_lane_shifter: four parallel-load lane shift registers presenting their MSBs, shifting left with zero fill
module led_lane_shifter
  import led_scan_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  input  logic [LANES-1:0][WORD_W-1:0] din,
  output logic [LANES-1:0] msb
);
  logic [LANES-1:0][WORD_W-1:0] sh;
  // zero fill leaves the registers clear after a full word, so sdo idles at 0 outside SHIFT
  always_ff @(posedge clk or posedge rst)
    if (rst) sh <= '0;
    else if (load) sh <= din;
    else if (shift) for (int i = 0; i < LANES; i++) sh[i] <= {sh[i][WORD_W-2:0], 1'b0};
  for (genvar i = 0; i < LANES; i++) assign msb[i] = sh[i][WORD_W-1];
endmodule

// File: rtl/led_scan_scheduler.sv
// led_scan_scheduler: round-robin LED panel refresh; define LED_SCAN_DIRTY_EN to refresh only written devices
module led_scan_scheduler
  import led_scan_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int WORD_W = 32,
  parameter int BLANK_CYC = 3
) (
  input logic clk,
  input logic rst,
  led_scan_if.slave bus
);
  localparam int DW = $clog2(NUM_DEV);
  localparam int CW = $clog2(WORD_W);
  localparam int BW = $clog2(BLANK_CYC + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(WORD_W - 1);
  localparam logic [BW-1:0] BLK_INIT = BW'(BLANK_CYC - 1);
  localparam logic [DW-1:0] DEV_LAST = DW'(NUM_DEV - 1);
  logic [2:0] state, nxt;
  logic [CW-1:0] bit_cnt;
  logic [BW-1:0] blk_cnt;
  logic [DW-1:0] cur_dev, dev_inc, pick;
  logic go, slot_end;
  logic [NUM_DEV-1:0][LANES-1:0][WORD_W-1:0] fb;
  logic [LANES-1:0] sdo;
  logic shift_en, blank, busy, dev_done;
  logic [NUM_DEV-1:0] latch;
  assign dev_inc = (cur_dev == DEV_LAST) ? '0 : cur_dev + 1'b1;
  assign slot_end = state == BLANK && blk_cnt == '0;
`ifdef LED_SCAN_DIRTY_EN
  logic [NUM_DEV-1:0] dirty;
  logic [DW-1:0] start, idx;
  assign start = (state == IDLE) ? cur_dev : dev_inc;
  // first dirty device at or after start, wrapping; clean devices cost no cycles
  always_comb begin
    pick = start;
    go = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      idx = DW'((int'(start) + k) % NUM_DEV);
      if (!go && dirty[idx]) begin
        pick = idx;
        go = 1'b1;
      end
    end
  end
  // a write marks its device dirty and wins over the clear at that device's LOAD
  always_ff @(posedge clk or posedge rst)
    if (rst) dirty <= '0;
    else dirty <= (dirty & ~((state == LOAD) ? NUM_DEV'(1) << cur_dev : '0))
                | (bus.wr_en ? NUM_DEV'(1) << bus.wr_dev : '0);
`else
  assign pick = (state == IDLE) ? cur_dev : dev_inc;
  assign go = 1'b1;
`endif
  assign nxt = (state == IDLE)  ? ((bus.enable && go) ? LOAD : IDLE) :
               (state == LOAD)  ? SHIFT :
               (state == SHIFT) ? ((bit_cnt == BIT_LAST) ? LATCH : SHIFT) :
               (state == LATCH) ? BLANK :
               (blk_cnt != '0)  ? BLANK :
               (bus.enable && go) ? LOAD : IDLE;
  // slot sequencing, counters and outputs registered from the next state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      blk_cnt <= '0;
      cur_dev <= '0;
      shift_en <= 1'b0;
      latch <= '0;
      blank <= 1'b1;
      busy <= 1'b0;
      dev_done <= 1'b0;
    end else begin
      state <= nxt;
      bit_cnt <= (state == SHIFT) ? bit_cnt + 1'b1 : '0;
      blk_cnt <= (state == LATCH) ? BLK_INIT : (blk_cnt != '0) ? blk_cnt - 1'b1 : '0;
      cur_dev <= ((state == IDLE && nxt == LOAD) || slot_end) ? ((nxt == LOAD) ? pick : dev_inc) : cur_dev;
      shift_en <= nxt == SHIFT;
      latch <= (nxt == LATCH) ? NUM_DEV'(1) << cur_dev : '0;
      blank <= !(nxt == LOAD || nxt == SHIFT);
      busy <= nxt != IDLE;
      dev_done <= nxt == BLANK && ((state == LATCH) ? BLK_INIT == '0 : blk_cnt == BW'(1));
    end
  // host writes touch only the buffer; a write during LOAD lands after the snapshot edge
  always_ff @(posedge clk or posedge rst)
    if (rst) fb <= '0;
    else if (bus.wr_en) fb[bus.wr_dev][bus.wr_lane] <= bus.wr_data;
  led_lane_shifter #(.WORD_W(WORD_W)) u_shift (
    .clk(clk),
    .rst(rst),
    .load(state == LOAD),
    .shift(state == SHIFT),
    .din(fb[cur_dev]),
    .msb(sdo)
  );
  assign bus.sdo = sdo;
  assign bus.shift_en = shift_en;
  assign bus.latch = latch;
  assign bus.blank = blank;
  assign bus.busy = busy;
  assign bus.cur_dev = cur_dev;
  assign bus.dev_done = dev_done;
endmodule

// File: tb/tb_led_scan_scheduler.sv
// tb_led_scan_scheduler: randomized bench checking every cycle against a slot-level reference model
module tb_led_scan_scheduler;
  import led_scan_pkg::*;
  localparam int N = 4, W = 32, B = 3, SLOT = 1 + W + 1 + B, DW = $clog2(N);
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  led_scan_if #(.NUM_DEV(N), .WORD_W(W)) bus ();
  led_scan_scheduler #(.NUM_DEV(N), .WORD_W(W), .BLANK_CYC(B)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  logic [W-1:0] mbuf [N][LANES];
  logic [W-1:0] snap [LANES];
  bit m_dirty [N];
  bit m_run, wrote, en;
  int m_p, m_d, guard, wp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      m_dirty[d] = 0;
      for (int l = 0; l < LANES; l++) mbuf[d][l] = '0;
    end
    m_run = 0;
    m_p = 0;
    m_d = 0;
  endtask

  function automatic int find_dirty(input int s);
    for (int k = 0; k < N; k++) if (m_dirty[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  // slot position p: 0 LOAD, 1..W SHIFT, W+1 LATCH, W+2..SLOT-1 BLANK
  task automatic check_outputs();
    logic [3:0] e_sdo;
    bit sh;
    sh = m_run && m_p >= 1 && m_p <= W;
    e_sdo = '0;
    if (sh) for (int i = 0; i < LANES; i++) e_sdo[i] = snap[i][W - m_p];
    check("sdo", bus.sdo, e_sdo);
    check("shift_en", bus.shift_en, sh);
    check("latch", bus.latch, (m_run && m_p == W + 1) ? (1 << m_d) : 0);
    check("blank", bus.blank, !(m_run && m_p <= W));
    check("busy", bus.busy, m_run);
    check("cur_dev", bus.cur_dev, m_d);
    check("dev_done", bus.dev_done, m_run && m_p == SLOT - 1);
  endtask

  task automatic cycle(input bit e, input bit we, input int dev, input int lane, input logic [W-1:0] data);
    int s, pk;
    @(posedge clk);
    #1;
    if (m_run && m_p == 0) begin
      for (int i = 0; i < LANES; i++) snap[i] = mbuf[m_d][i];
      m_dirty[m_d] = 0;
    end
    check_outputs();
    bus.enable = e;
    bus.wr_en = we;
    bus.wr_dev = DW'(dev);
    bus.wr_lane = 2'(lane);
    bus.wr_data = data;
    if (m_run) begin
      m_p++;
      if (m_p == SLOT) begin
        s = (m_d + 1) % N;
        m_p = 0;
`ifdef LED_SCAN_DIRTY_EN
        pk = find_dirty(s);
        m_run = e && pk >= 0;
        m_d = m_run ? pk : s;
`else
        pk = s;
        m_run = e;
        m_d = pk;
`endif
      end
    end else begin
`ifdef LED_SCAN_DIRTY_EN
      pk = find_dirty(m_d);
      if (e && pk >= 0) begin
        m_run = 1;
        m_d = pk;
        m_p = 0;
      end
`else
      if (e) begin
        m_run = 1;
        m_p = 0;
      end
`endif
    end
    if (we) begin
      mbuf[dev][lane] = data;
      m_dirty[dev] = 1;
    end
  endtask

  task automatic async_reset();
    #2 rst = 1;
    bus.enable = 0;
    bus.wr_en = 0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    model_reset();
    bus.enable = 0;
    bus.wr_en = 0;
    bus.wr_dev = '0;
    bus.wr_lane = '0;
    bus.wr_data = '0;
    #6;
    check_outputs();
    #1 rst = 0;
    repeat (4) cycle(0, 0, 0, 0, '0);
    for (int l = 0; l < LANES; l++) cycle(0, 1, 0, l, 32'b1011);
    wrote = 0;
    for (int c = 0; c < 4 * SLOT + 4; c++)
      if (!wrote && m_run && m_d == 0 && m_p == 10) begin
        cycle(1, 1, 0, LANE_A, 32'hFFFF_FFFF);
        wrote = 1;
      end else cycle(1, 0, 0, 0, '0);
    cycle(1, 1, 1, LANE_B, $urandom);
    guard = 0;
    while (!(m_run && m_p == 11) && guard < 4 * SLOT) begin
      cycle(1, 0, 0, 0, '0);
      guard++;
    end
    repeat (SLOT + 6) cycle(0, 0, 0, 0, '0);
    for (int ph = 0; ph < 2; ph++) begin
      wp = ph == 0 ? 3 : 60;
      en = 1;
      for (int c = 0; c < 2500; c++) begin
        if ($urandom_range(0, 199) == 0) en = !en;
        cycle(en, $urandom_range(0, wp - 1) == 0, $urandom_range(0, N - 1), $urandom_range(0, LANES - 1), $urandom);
      end
    end
    cycle(1, 1, 2, LANE_C, $urandom);
    guard = 0;
    while (!(m_run && m_p == 7) && guard < 4 * SLOT) begin
      cycle(1, 0, 0, 0, '0);
      guard++;
    end
    async_reset();
    cycle(1, 1, 0, LANE_A, '0);
    repeat (SLOT + 4) cycle(1, 0, 0, 0, '0);
`ifdef LED_SCAN_DIRTY_EN
    async_reset();
    repeat (5) cycle(1, 0, 0, 0, '0);
    cycle(1, 1, 2, LANE_D, $urandom);
    repeat (SLOT + 8) cycle(1, 0, 0, 0, '0);
    cycle(0, 1, 1, LANE_A, $urandom);
    cycle(0, 1, 3, LANE_B, $urandom);
    repeat (2 * SLOT + 8) cycle(1, 0, 0, 0, '0);
`endif
    repeat (3) cycle(0, 0, 0, 0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
